l2_arbiter: RTL and testbench

L2_ARBITER -- requirements
Module: l2_arbiter

---
 rtl/lc3b_types.sv | 15 +
 rtl/l2_arbiter.sv | 122 ++++++++++++
 tb/tb_l2_arbiter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// Shared types and default widths for the LC-3b memory hierarchy.
// Holds the L2 arbiter state encoding.
package lc3b_types;

  localparam int DEFAULT_ADDR_W = 16;
  localparam int DEFAULT_LINE_W = 128;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/l2_arbiter.sv
// Arbitrates I-cache and D-cache line traffic onto a single L2 port.
// Simultaneous requests alternate; each transaction is followed by a one-cycle release gap.
module l2_arbiter
  import lc3b_types::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int LINE_W = DEFAULT_LINE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] icache_pmem_address,
  input  logic              icache_pmem_read,
  output logic [LINE_W-1:0] icache_pmem_rdata,
  output logic              icache_pmem_resp,
  input  logic [ADDR_W-1:0] dcache_pmem_address,
  input  logic              dcache_pmem_read,
  input  logic              dcache_pmem_write,
  input  logic [LINE_W-1:0] dcache_pmem_wdata,
  output logic [LINE_W-1:0] dcache_pmem_rdata,
  output logic              dcache_pmem_resp,
  output logic [ADDR_W-1:0] l2_address,
  output logic              l2_read,
  output logic              l2_write,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp
);

  arb_state_t state_r;
  arb_state_t next_state_s;
  logic       last_grant_r;
  logic       next_last_grant_s;
  logic       d_write_r;
  logic       next_d_write_s;
  logic       i_pend_s;
  logic       d_pend_s;

  assign i_pend_s = icache_pmem_read;
  assign d_pend_s = dcache_pmem_read | dcache_pmem_write;

  // State, fairness bit and latched D-side operation register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      d_write_r    <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      last_grant_r <= next_last_grant_s;
      d_write_r    <= next_d_write_s;
    end
  end

  // Next-state selection and L2/requester output muxing.
  always_comb begin
    next_state_s      = state_r;
    next_last_grant_s = last_grant_r;
    next_d_write_s    = d_write_r;
    l2_address        = '0;
    l2_read           = 1'b0;
    l2_write          = 1'b0;
    l2_wdata          = '0;
    icache_pmem_rdata = '0;
    icache_pmem_resp  = 1'b0;
    dcache_pmem_rdata = '0;
    dcache_pmem_resp  = 1'b0;
    case (state_r)
      IDLE: begin
        // The D operation is captured at grant so a dropped request cannot cancel the L2 command.
        next_d_write_s = dcache_pmem_write;
        if (i_pend_s && d_pend_s) begin
          if (last_grant_r) begin
            next_state_s      = SERVE_I;
            next_last_grant_s = 1'b0;
          end else begin
            next_state_s      = SERVE_D;
            next_last_grant_s = 1'b1;
          end
        end else if (i_pend_s) begin
          next_state_s      = SERVE_I;
          next_last_grant_s = 1'b0;
        end else if (d_pend_s) begin
          next_state_s      = SERVE_D;
          next_last_grant_s = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      SERVE_I: begin
        l2_address = icache_pmem_address;
        l2_read    = 1'b1;
        if (l2_resp) begin
          icache_pmem_resp  = 1'b1;
          icache_pmem_rdata = l2_rdata;
          next_state_s      = RELEASE;
        end else begin
          next_state_s = SERVE_I;
        end
      end
      SERVE_D: begin
        l2_address = dcache_pmem_address;
        l2_read    = ~d_write_r;
        l2_write   = d_write_r;
        l2_wdata   = dcache_pmem_wdata;
        if (l2_resp) begin
          dcache_pmem_resp  = 1'b1;
          dcache_pmem_rdata = l2_rdata;
          next_state_s      = RELEASE;
        end else begin
          next_state_s = SERVE_D;
        end
      end
      RELEASE: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed scoreboard bench for l2_arbiter: stimulus pushes expected responses,
// a negedge monitor pops and compares them whenever a requester resp appears.
module tb_l2_arbiter;

  localparam int AW = 16;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] icache_pmem_address = '0;
  logic          icache_pmem_read = 1'b0;
  logic [LW-1:0] icache_pmem_rdata;
  logic          icache_pmem_resp;
  logic [AW-1:0] dcache_pmem_address = '0;
  logic          dcache_pmem_read = 1'b0;
  logic          dcache_pmem_write = 1'b0;
  logic [LW-1:0] dcache_pmem_wdata = '0;
  logic [LW-1:0] dcache_pmem_rdata;
  logic          dcache_pmem_resp;
  logic [AW-1:0] l2_address;
  logic          l2_read;
  logic          l2_write;
  logic [LW-1:0] l2_wdata;
  logic [LW-1:0] l2_rdata = '0;
  logic          l2_resp = 1'b0;

  typedef struct packed {
    logic          side;
    logic [LW-1:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   passed = 0;

  localparam logic [LW-1:0] A5_LINE = {16{8'hA5}};
  localparam logic [LW-1:0] WD_LINE = {2{64'h0123_4567_89AB_CDEF}};
  localparam logic [LW-1:0] WD2_LINE = {4{32'hCAFE_F00D}};

  l2_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .icache_pmem_address(icache_pmem_address), .icache_pmem_read(icache_pmem_read),
    .icache_pmem_rdata(icache_pmem_rdata), .icache_pmem_resp(icache_pmem_resp),
    .dcache_pmem_address(dcache_pmem_address), .dcache_pmem_read(dcache_pmem_read),
    .dcache_pmem_write(dcache_pmem_write), .dcache_pmem_wdata(dcache_pmem_wdata),
    .dcache_pmem_rdata(dcache_pmem_rdata), .dcache_pmem_resp(dcache_pmem_resp),
    .l2_address(l2_address), .l2_read(l2_read), .l2_write(l2_write),
    .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One granted transaction: wait for the command, check it, hold, respond, check release and idle.
  task automatic serve(input logic side, input logic [AW-1:0] addr, input logic exp_rd,
                       input logic exp_wr, input logic [LW-1:0] exp_wd, input int dly,
                       input logic [LW-1:0] rdata, input logic [1:0] drop, input logic spur,
                       input logic early);
    int   n = 0;
    exp_t e;
    while (!(l2_read || l2_write) && n < 20) begin
      tick();
      n++;
    end
    chk("grant_latency", n, 1);
    chk("cmd_address", l2_address, addr);
    chk("cmd_read", l2_read, exp_rd);
    chk("cmd_write", l2_write, exp_wr);
    chk("cmd_wdata", l2_wdata, exp_wd);
    if (early) begin
      if (side) begin
        dcache_pmem_read  = 1'b0;
        dcache_pmem_write = 1'b0;
      end else begin
        icache_pmem_read = 1'b0;
      end
    end
    for (int i = 0; i < dly; i++) begin
      tick();
      chk("hold_read", l2_read, exp_rd);
      chk("hold_write", l2_write, exp_wr);
      chk("hold_address", l2_address, addr);
      chk("hold_wdata", l2_wdata, exp_wd);
    end
    e.side  = side;
    e.rdata = rdata;
    exp_q.push_back(e);
    l2_rdata = rdata;
    l2_resp  = 1'b1;
    tick();
    l2_resp  = spur;
    l2_rdata = spur ? 128'hDEAD : 128'h0;
    if (drop[0]) icache_pmem_read = 1'b0;
    if (drop[1]) begin
      dcache_pmem_read  = 1'b0;
      dcache_pmem_write = 1'b0;
    end
    #1;
    chk("release_read", l2_read, 1'b0);
    chk("release_write", l2_write, 1'b0);
    chk("release_iresp", icache_pmem_resp, 1'b0);
    chk("release_dresp", dcache_pmem_resp, 1'b0);
    tick();
    l2_resp  = 1'b0;
    l2_rdata = '0;
    chk("idle_read", l2_read, 1'b0);
    chk("idle_write", l2_write, 1'b0);
  endtask

  // Scoreboard monitor: every requester resp must match the oldest expectation.
  always @(negedge clk) begin
    if (icache_pmem_resp || dcache_pmem_resp) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", {icache_pmem_resp, dcache_pmem_resp}, 2'b00);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_side", dcache_pmem_resp, mon_e.side);
        chk("resp_single", icache_pmem_resp && dcache_pmem_resp, 1'b0);
        chk("resp_rdata", mon_e.side ? dcache_pmem_rdata : icache_pmem_rdata, mon_e.rdata);
        chk("other_rdata", mon_e.side ? icache_pmem_rdata : dcache_pmem_rdata, '0);
      end
    end
  end

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_read", l2_read, 1'b0);
    chk("rst_write", l2_write, 1'b0);
    chk("rst_address", l2_address, '0);
    chk("rst_wdata", l2_wdata, '0);
    chk("rst_iresp", icache_pmem_resp, 1'b0);
    chk("rst_dresp", dcache_pmem_resp, 1'b0);
    rst_n = 1'b1;
    tick();

    // Solo I read, response on third command cycle
    icache_pmem_address = 16'h1000;
    icache_pmem_read    = 1'b1;
    serve(1'b0, 16'h1000, 1'b1, 1'b0, '0, 2, A5_LINE, 2'b01, 1'b0, 1'b0);

    // D writeback with read also high: write wins
    dcache_pmem_address = 16'h2040;
    dcache_pmem_wdata   = WD_LINE;
    dcache_pmem_read    = 1'b1;
    dcache_pmem_write   = 1'b1;
    serve(1'b1, 16'h2040, 1'b0, 1'b1, WD_LINE, 1, 128'h5A5A, 2'b10, 1'b0, 1'b0);

    // Fresh reset, then simultaneous requests held: I, D, I, D
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    icache_pmem_address = 16'h1100;
    icache_pmem_read    = 1'b1;
    dcache_pmem_address = 16'h2200;
    dcache_pmem_wdata   = '0;
    dcache_pmem_read    = 1'b1;
    serve(1'b0, 16'h1100, 1'b1, 1'b0, '0, 0, 128'h11, 2'b00, 1'b0, 1'b0);
    serve(1'b1, 16'h2200, 1'b1, 1'b0, '0, 1, 128'h22, 2'b00, 1'b0, 1'b0);
    serve(1'b0, 16'h1100, 1'b1, 1'b0, '0, 0, 128'h33, 2'b00, 1'b0, 1'b0);
    serve(1'b1, 16'h2200, 1'b1, 1'b0, '0, 0, 128'h44, 2'b11, 1'b0, 1'b0);

    // Spurious l2_resp in IDLE, then in RELEASE
    l2_rdata = 128'hBEEF;
    l2_resp  = 1'b1;
    #1;
    chk("spur_idle_iresp", icache_pmem_resp, 1'b0);
    chk("spur_idle_dresp", dcache_pmem_resp, 1'b0);
    tick();
    l2_resp  = 1'b0;
    l2_rdata = '0;
    chk("spur_idle_state", l2_read, 1'b0);
    icache_pmem_address = 16'h1300;
    icache_pmem_read    = 1'b1;
    serve(1'b0, 16'h1300, 1'b1, 1'b0, '0, 1, 128'h55, 2'b01, 1'b1, 1'b0);

    // Reset mid SERVE_D with an I request pending
    dcache_pmem_address = 16'h3000;
    dcache_pmem_wdata   = WD2_LINE;
    dcache_pmem_write   = 1'b1;
    tick();
    chk("rstmid_write_on", l2_write, 1'b1);
    icache_pmem_address = 16'h1400;
    icache_pmem_read    = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_write", l2_write, 1'b0);
    chk("rstmid_read", l2_read, 1'b0);
    chk("rstmid_address", l2_address, '0);
    chk("rstmid_wdata", l2_wdata, '0);
    l2_rdata = 128'h77;
    l2_resp  = 1'b1;
    #1;
    chk("rstmid_dresp", dcache_pmem_resp, 1'b0);
    chk("rstmid_iresp", icache_pmem_resp, 1'b0);
    tick();
    l2_resp           = 1'b0;
    l2_rdata          = '0;
    dcache_pmem_write = 1'b0;
    rst_n             = 1'b1;
    serve(1'b0, 16'h1400, 1'b1, 1'b0, '0, 0, 128'h66, 2'b01, 1'b0, 1'b0);

    // D drops its write mid transaction; command must persist until l2_resp
    dcache_pmem_address = 16'h4080;
    dcache_pmem_wdata   = WD2_LINE;
    dcache_pmem_write   = 1'b1;
    serve(1'b1, 16'h4080, 1'b0, 1'b1, WD2_LINE, 3, 128'h88, 2'b10, 1'b0, 1'b1);
    tick();
    chk("no_regrant", l2_write | l2_read, 1'b0);

    repeat (2) tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
